// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register file.
//   i2c_state_e : target protocol FSM states
//   I2C_ACK/NACK: SDA level of the ninth (acknowledge) bit
//   ptr_width() : register-pointer width for a given register count
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WR,
      ST_WR_ACK,
      ST_RD,
      ST_RD_ACK,
      ST_IGNORE
   } i2c_state_e;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   function automatic int ptr_width(input int num_regs);
      return (num_regs > 2) ? $clog2(num_regs) : 1;
   endfunction

endpackage

// File: rtl/i2c_in_filter.sv
// 2-FF synchronizer followed by a glitch filter for one I2C line.
//   clk, rst_n : clock, synchronous active-low reset
//   din        : raw pin value
//   level      : filtered level (idles high, like the bus)
//   rise, fall : one-cycle pulses coincident with a filtered level change
// A new level is accepted only after FILTER_LEN consecutive synchronized
// samples that differ from the current filtered level.
module i2c_in_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         level  <= 1'b1;
         cnt    <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], din};
         rise   <= 1'b0;
         fall   <= 1'b0;
         if (sync_q[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            // this is the FILTER_LEN-th differing sample in a row
            level <= sync_q[1];
            cnt   <= '0;
            rise  <= sync_q[1];
            fall  <= !sync_q[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an auto-incrementing byte register file.
//   clk, rst_n          : clock (>= 20x SCL), synchronous active-low reset
//   i2c_scl_*/i2c_sda_* : split open-drain pins; only SDA is ever driven
//   regs                : flattened register file, reg k at [8k+7:8k]
//   wr_stb/addr/data    : one-cycle notification of each accepted data byte
//   busy                : addressed transaction in progress (until STOP)
// Protocol: S, {DEV_ADDR,0}, ptr, data... P   writes from ptr upward
//           S, {DEV_ADDR,1}, data... (NACK) P  reads from ptr upward
module i2c_target_regfile
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR   = 7'h50,
   parameter int         NUM_REGS   = 16,
   parameter int         FILTER_LEN = 3
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i2c_scl_i,
   output logic                             i2c_scl_o,
   output logic                             i2c_scl_t,
   input  logic                             i2c_sda_i,
   output logic                             i2c_sda_o,
   output logic                             i2c_sda_t,
   output logic [NUM_REGS*8-1:0]            regs,
   output logic                             wr_stb,
   output logic [ptr_width(NUM_REGS)-1:0]   wr_addr,
   output logic [7:0]                       wr_data,
   output logic                             busy
);

   localparam int PW = ptr_width(NUM_REGS);

   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;

   i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .clk(clk), .rst_n(rst_n), .din(i2c_scl_i),
      .level(scl), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .clk(clk), .rst_n(rst_n), .din(i2c_sda_i),
      .level(sda), .rise(sda_rise), .fall(sda_fall)
   );

   i2c_state_e                 state, state_n;
   logic [NUM_REGS-1:0][7:0]   reg_q;
   logic [PW-1:0]              ptr;
   logic [6:0]                 sh;        // rx: bits seen so far; tx: bits still to send
   logic [2:0]                 bit_cnt;
   logic                       ack_phase; // ack states: bit 9 in progress; RD_ACK: master ACKed
   logic                       rw;
   logic                       sda_t_q;
   logic                       busy_q;

   logic       start_c, stop_c, byte_done, ack_end, addr_hit, load_rd;
   logic [7:0] rx_byte;

   assign start_c   = sda_fall && scl;
   assign stop_c    = sda_rise && scl;
   assign byte_done = scl_rise && (bit_cnt == 3'd7);
   assign ack_end   = scl_fall && ack_phase;
   assign rx_byte   = {sh, sda};
   assign addr_hit  = (sh == DEV_ADDR);
   // a read byte is loaded on the fall that ends an ACK leading into RD
   assign load_rd   = ack_end && ((state == ST_ADDR_ACK && rw) || state == ST_RD_ACK);

   assign i2c_scl_o = 1'b0;
   assign i2c_scl_t = 1'b1;
   assign i2c_sda_o = 1'b0;
   assign i2c_sda_t = sda_t_q;
   assign busy      = busy_q;
   assign regs      = reg_q;

   always_comb begin
      state_n = state;
      if (start_c) begin
         state_n = ST_ADDR;
      end else if (stop_c) begin
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_ADDR:     if (byte_done) state_n = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
            ST_PTR:      if (byte_done) state_n = ST_PTR_ACK;
            ST_WR:       if (byte_done) state_n = ST_WR_ACK;
            ST_ADDR_ACK: if (ack_end) state_n = rw ? ST_RD : ST_PTR;
            ST_PTR_ACK,
            ST_WR_ACK:   if (ack_end) state_n = ST_WR;
            ST_RD:       if (scl_fall && bit_cnt == 3'd7) state_n = ST_RD_ACK;
            ST_RD_ACK: begin
               if (scl_rise && sda == I2C_NACK) state_n = ST_IGNORE;
               else if (ack_end)                state_n = ST_RD;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         reg_q     <= '0;
         ptr       <= '0;
         sh        <= '0;
         bit_cnt   <= '0;
         ack_phase <= 1'b0;
         rw        <= 1'b0;
         sda_t_q   <= 1'b1;
         busy_q    <= 1'b0;
         wr_stb    <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
      end else begin
         state  <= state_n;
         wr_stb <= 1'b0;
         if (start_c || stop_c) begin
            // any bus condition abandons the byte in flight
            bit_cnt   <= '0;
            ack_phase <= 1'b0;
            sda_t_q   <= 1'b1;
            if (stop_c) busy_q <= 1'b0;
         end else begin
            case (state)
               ST_ADDR, ST_PTR, ST_WR: begin
                  if (scl_rise) begin
                     sh      <= rx_byte[6:0];
                     bit_cnt <= bit_cnt + 3'd1;
                  end
                  if (byte_done) begin
                     ack_phase <= 1'b0;
                     if (state == ST_ADDR) begin
                        rw <= sda;
                        if (addr_hit) busy_q <= 1'b1;
                     end else if (state == ST_PTR) begin
                        ptr <= rx_byte[PW-1:0];
                     end else begin
                        reg_q[ptr] <= rx_byte;
                        wr_stb     <= 1'b1;
                        wr_addr    <= ptr;
                        wr_data    <= rx_byte;
                        ptr        <= ptr + 1'b1;
                     end
                  end
               end
               ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                  // first fall ends bit 8 -> pull low; second ends bit 9 -> release
                  if (scl_fall) begin
                     sda_t_q   <= ack_phase ? 1'b1 : I2C_ACK;
                     ack_phase <= !ack_phase;
                     bit_cnt   <= '0;
                  end
               end
               ST_RD: begin
                  if (scl_fall) begin
                     if (bit_cnt == 3'd7) begin
                        sda_t_q   <= 1'b1;
                        ptr       <= ptr + 1'b1;
                        bit_cnt   <= '0;
                        ack_phase <= 1'b0;
                     end else begin
                        sda_t_q <= sh[6];
                        sh      <= {sh[5:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise && sda == I2C_ACK) ack_phase <= 1'b1;
                  if (ack_end) ack_phase <= 1'b0;
               end
               default: sda_t_q <= 1'b1;
            endcase
            if (load_rd) begin
               sda_t_q <= reg_q[ptr][7];
               sh      <= reg_q[ptr][6:0];
               bit_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bus-master tasks drive SCL/SDA,
// expected values are hand-computed from the transaction sequence.
module tb_i2c_target_regfile;

   localparam int Q = 10;   // quarter SCL period in clk cycles

   logic         clk = 1'b0;
   logic         rst_n, scl_drv, sda_drv;
   logic         i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t;
   logic [127:0] regs;
   logic         wr_stb, busy;
   logic [3:0]   wr_addr;
   logic [7:0]   wr_data;
   logic         scl_line, sda_line;

   always #5 clk = ~clk;

   assign scl_line = scl_drv & (i2c_scl_t | i2c_scl_o);
   assign sda_line = sda_drv & (i2c_sda_t | i2c_sda_o);

   i2c_target_regfile dut (
      .clk(clk), .rst_n(rst_n),
      .i2c_scl_i(scl_line), .i2c_scl_o(i2c_scl_o), .i2c_scl_t(i2c_scl_t),
      .i2c_sda_i(sda_line), .i2c_sda_o(i2c_sda_o), .i2c_sda_t(i2c_sda_t),
      .regs(regs), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy)
   );

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [11:0] wr_log [0:63];
   int          wr_n = 0;
   int          low_cnt = 0;
   int          busy_cnt = 0;
   logic        glitch_en = 1'b0;

   always @(negedge clk) begin
      if (rst_n && wr_stb && wr_n < 64) begin
         wr_log[wr_n] = {wr_addr, wr_data};
         wr_n++;
      end
      if (!i2c_sda_t) low_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] reg_at(input int k);
      return regs[8*k +: 8];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_drv = 1'b1; tick(Q);
      scl_drv = 1'b1; tick(Q);
      sda_drv = 1'b0; tick(Q);
      scl_drv = 1'b0; tick(Q);
   endtask

   task automatic bus_stop();
      sda_drv = 1'b0; tick(Q);
      scl_drv = 1'b1; tick(Q);
      sda_drv = 1'b1; tick(Q);
   endtask

   task automatic send_bit(input logic b);
      sda_drv = b;
      if (glitch_en) begin
         tick(2); scl_drv = 1'b1; tick(1); scl_drv = 1'b0;   // 1-clk spike
         tick(2); scl_drv = 1'b1; tick(2); scl_drv = 1'b0;   // 2-clk spike
         tick(Q - 7);
      end else begin
         tick(Q);
      end
      scl_drv = 1'b1;
      if (glitch_en) begin
         tick(8); scl_drv = 1'b0; tick(1); scl_drv = 1'b1; tick(11);
      end else begin
         tick(2 * Q);
      end
      scl_drv = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_drv = 1'b1; tick(Q);
      scl_drv = 1'b1; tick(Q);
      ack = sda_line; tick(Q);
      scl_drv = 1'b0; tick(Q);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic [7:0] t;
      t = '0;
      for (int i = 7; i >= 0; i--) begin
         sda_drv = 1'b1; tick(Q);
         scl_drv = 1'b1; tick(Q);
         t[i] = sda_line; tick(Q);
         scl_drv = 1'b0; tick(Q);
      end
      send_bit(mack);
      d = t;
   endtask

   logic [7:0]   a, rd;
   logic [127:0] regs_snap;
   int           lc0, bc0, wn0;
   logic [7:0]   b6;

   initial begin
      rst_n = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1;
      tick(5);
      check("rst_sda_t", 32'(i2c_sda_t), 32'd1);
      check("rst_scl_t", 32'(i2c_scl_t), 32'd1);
      check("rst_sda_o", 32'(i2c_sda_o), 32'd0);
      check("rst_scl_o", 32'(i2c_scl_o), 32'd0);
      check("rst_regs0", 32'(regs == '0), 32'd1);
      check("rst_wr_stb", 32'(wr_stb), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      tick(10);

      // 1: write burst S A0 03 11 22 P
      bus_start();
      write_byte(8'hA0, a); check("wb_ack_addr", 32'(a), 32'd0);
      check("wb_busy", 32'(busy), 32'd1);
      write_byte(8'h03, a); check("wb_ack_ptr", 32'(a), 32'd0);
      write_byte(8'h11, a); check("wb_ack_d0", 32'(a), 32'd0);
      write_byte(8'h22, a); check("wb_ack_d1", 32'(a), 32'd0);
      bus_stop();
      tick(10);
      check("wb_reg3", 32'(reg_at(3)), 32'h11);
      check("wb_reg4", 32'(reg_at(4)), 32'h22);
      check("wb_nstb", 32'(wr_n), 32'd2);
      check("wb_stb0", 32'(wr_log[0]), 32'h311);
      check("wb_stb1", 32'(wr_log[1]), 32'h422);
      check("wb_busy_post", 32'(busy), 32'd0);

      // 2: S A0 03 Sr A1 rd(ACK) rd(NACK) P
      bus_start();
      write_byte(8'hA0, a); check("rd_ack_addr", 32'(a), 32'd0);
      write_byte(8'h03, a); check("rd_ack_ptr", 32'(a), 32'd0);
      bus_start();
      write_byte(8'hA1, a); check("rd_ack_raddr", 32'(a), 32'd0);
      read_byte(1'b0, rd);  check("rd_byte0", 32'(rd), 32'h11);
      read_byte(1'b1, rd);  check("rd_byte1", 32'(rd), 32'h22);
      check("rd_released", 32'(i2c_sda_t), 32'd1);
      bus_stop();
      tick(10);
      check("rd_busy_post", 32'(busy), 32'd0);

      // 3: address mismatch S A2 00 P
      regs_snap = regs; lc0 = low_cnt; bc0 = busy_cnt; wn0 = wr_n;
      bus_start();
      write_byte(8'hA2, a); check("mm_nack_addr", 32'(a), 32'd1);
      write_byte(8'h00, a); check("mm_nack_data", 32'(a), 32'd1);
      bus_stop();
      tick(10);
      check("mm_sda_never_low", 32'(low_cnt - lc0), 32'd0);
      check("mm_busy_never", 32'(busy_cnt - bc0), 32'd0);
      check("mm_regs_same", 32'(regs == regs_snap), 32'd1);
      check("mm_no_stb", 32'(wr_n - wn0), 32'd0);

      // 4: pointer wrap at 15, then pointer 0x13 -> 3
      bus_start();
      write_byte(8'hA0, a); write_byte(8'h0F, a);
      write_byte(8'hAA, a); write_byte(8'hBB, a);
      bus_stop();
      tick(10);
      check("wrap_reg15", 32'(reg_at(15)), 32'hAA);
      check("wrap_reg0", 32'(reg_at(0)), 32'hBB);
      check("wrap_stb1", 32'(wr_log[3]), 32'h0BB);
      bus_start();
      write_byte(8'hA0, a); write_byte(8'h13, a);
      bus_stop();
      bus_start();
      write_byte(8'hA1, a);
      read_byte(1'b1, rd);
      bus_stop();
      check("ptr_mod_read", 32'(rd), 32'h11);

      // 5: SCL glitches during a data write
      bus_start();
      write_byte(8'hA0, a); write_byte(8'h05, a);
      glitch_en = 1'b1;
      write_byte(8'h5A, a);
      glitch_en = 1'b0;
      check("gl_ack", 32'(a), 32'd0);
      bus_stop();
      tick(10);
      check("gl_reg5", 32'(reg_at(5)), 32'h5A);
      check("gl_nstb", 32'(wr_n), 32'd5);
      check("gl_stb", 32'(wr_log[4]), 32'h55A);

      // 6a: STOP after 5 bits of a data byte
      b6 = reg_at(6); wn0 = wr_n;
      bus_start();
      write_byte(8'hA0, a); write_byte(8'h06, a);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      bus_stop();
      tick(10);
      check("ab_reg6", 32'(reg_at(6)), 32'(b6));
      check("ab_no_stb", 32'(wr_n - wn0), 32'd0);
      check("ab_busy", 32'(busy), 32'd0);

      // 6b: reset while the address ACK is being driven
      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(a_bit(i));
      check("rs_ack_driven", 32'(i2c_sda_t), 32'd0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rs_sda_t", 32'(i2c_sda_t), 32'd1);
      check("rs_busy", 32'(busy), 32'd0);
      check("rs_regs0", 32'(regs == '0), 32'd1);
      check("rs_wr_addr", 32'(wr_addr), 32'd0);
      check("rs_wr_data", 32'(wr_data), 32'd0);
      sda_drv = 1'b1; scl_drv = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   function automatic logic a_bit(input int i);
      logic [7:0] v;
      v = 8'hA0;
      return v[i];
   endfunction

endmodule
